// File: rtl/ssd_scan_if.sv
// ssd_scan_if: load request from the adder side plus the display outputs.
//   sum[7:0]  unsigned magnitude to show
//   sign      1 = negative
//   load      one-cycle capture request
//   busy      conversion in progress, load ignored while high
//   done      one-cycle pulse when the display registers update
//   an[3:0]   digit enables, active low (an[3] = sign digit)
//   seg[6:0]  {g,f,e,d,c,b,a}, active low
//   dp        decimal point, active low, constant 1
interface ssd_scan_if;
  logic [7:0] sum;
  logic       sign;
  logic       load;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output sum, sign, load, input busy, done, an, seg, dp);
  modport slave  (input sum, sign, load, output busy, done, an, seg, dp);
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: converts an 8-bit magnitude plus sign to BCD with a
// sequential shift-add-3 (one bit per clock) and time-multiplexes the result
// on a 4-digit common-anode seven-segment display.
//   clk         system clock
//   rst         synchronous active-high reset
//   bus.slave   sum/sign/load in; busy/done/an/seg/dp out
//   REFRESH_BITS width of the free-running scan counter (top 2 bits = digit)
// Optional build macro SSD_LEADING_ZERO_BLANK_EN: blanks leading zero
// hundreds/tens digits; the ones digit is always shown.
module ssd_scan_driver #(
  parameter int unsigned REFRESH_BITS = 18
) (
  input logic        clk,
  input logic        rst,
  ssd_scan_if.slave  bus
);

  localparam int unsigned SUM_W  = 8;
  localparam int unsigned BCD_W  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                  state_q, state_n;
  logic [SUM_W-1:0]        shift_q, shift_n;
  logic [BCD_W-1:0]        bcd_q, bcd_n, bcd_adj;
  logic [CNT_W-1:0]        bitcnt_q, bitcnt_n;
  logic                    sign_tmp_q, sign_tmp_n;
  logic [1:0]              disp_h_q, disp_h_n;
  logic [3:0]              disp_t_q, disp_t_n;
  logic [3:0]              disp_o_q, disp_o_n;
  logic                    disp_sign_q, disp_sign_n;
  logic [REFRESH_BITS-1:0] cnt_q, cnt_n;
  logic [3:0]              an_q, an_n;
  logic [SEG_W-1:0]        seg_q, seg_n;
  logic                    busy_q, busy_n;
  logic                    done_q, done_n;
  logic [1:0]              sel;
  logic                    blank_h, blank_t;

  // BCD nibble to active-low segment code; anything above 9 is blank.
  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  assign sel = cnt_q[REFRESH_BITS-1 -: 2];

`ifdef SSD_LEADING_ZERO_BLANK_EN
  assign blank_h = (disp_h_q == 2'd0);
  assign blank_t = (disp_h_q == 2'd0) && (disp_t_q == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  // Next-state, conversion datapath and scan output decode.
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    bcd_n       = bcd_q;
    bcd_adj     = bcd_q;
    bitcnt_n    = bitcnt_q;
    sign_tmp_n  = sign_tmp_q;
    disp_h_n    = disp_h_q;
    disp_t_n    = disp_t_q;
    disp_o_n    = disp_o_q;
    disp_sign_n = disp_sign_q;
    done_n      = 1'b0;
    cnt_n       = cnt_q + REFRESH_BITS'(1);
    an_n        = 4'hF;
    seg_n       = SEG_BLANK;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_n    = bus.sum;
          sign_tmp_n = bus.sign;
          bcd_n      = '0;
          bitcnt_n   = '0;
          state_n    = CONV;
        end
      end
      CONV: begin
        // Hundreds never exceeds 2, so only tens and ones need the +3 fix.
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        bcd_n    = {bcd_adj[BCD_W-2:0], shift_q[SUM_W-1]};
        shift_n  = {shift_q[SUM_W-2:0], 1'b0};
        bitcnt_n = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd7) state_n = DONE;
      end
      DONE: begin
        disp_h_n    = bcd_q[9:8];
        disp_t_n    = bcd_q[7:4];
        disp_o_n    = bcd_q[3:0];
        // Negative zero shows a blank sign digit.
        disp_sign_n = sign_tmp_q && (bcd_q != '0);
        done_n      = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);

    case (sel)
      2'd0: begin
        an_n  = 4'b1110;
        seg_n = seg_of(disp_o_q);
      end
      2'd1: begin
        an_n  = 4'b1101;
        seg_n = blank_t ? SEG_BLANK : seg_of(disp_t_q);
      end
      2'd2: begin
        an_n  = 4'b1011;
        seg_n = blank_h ? SEG_BLANK : seg_of({2'b00, disp_h_q});
      end
      default: begin
        an_n  = 4'b0111;
        seg_n = disp_sign_q ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      bitcnt_q    <= '0;
      sign_tmp_q  <= 1'b0;
      disp_h_q    <= '0;
      disp_t_q    <= '0;
      disp_o_q    <= '0;
      disp_sign_q <= 1'b0;
      cnt_q       <= '0;
      an_q        <= 4'hF;
      seg_q       <= SEG_BLANK;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      shift_q     <= shift_n;
      bcd_q       <= bcd_n;
      bitcnt_q    <= bitcnt_n;
      sign_tmp_q  <= sign_tmp_n;
      disp_h_q    <= disp_h_n;
      disp_t_q    <= disp_t_n;
      disp_o_q    <= disp_o_n;
      disp_sign_q <= disp_sign_n;
      cnt_q       <= cnt_n;
      an_q        <= an_n;
      seg_q       <= seg_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: table-driven and randomized checks of ssd_scan_driver
// with REFRESH_BITS=4; expected digits come from decimal arithmetic.
module tb_ssd_scan_driver;

  localparam int unsigned RB = 4;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  ssd_scan_if bus();

  ssd_scan_driver #(.REFRESH_BITS(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] code_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z0 = 7'h7F;
  localparam bit LZB = 1'b1;
`else
  localparam logic [6:0] Z0 = 7'h40;
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [7:0] sum;
    logic       sign;
    int         extra_at;
    logic [6:0] e_s, e_h, e_t, e_o;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decimal reference: digits from / and %, blanking from the display rules.
  task automatic model(input int s, input bit sg,
                       output logic [6:0] es, eh, et, eo);
    int h, t, o;
    h = s / 100;
    t = (s / 10) % 10;
    o = s % 10;
    es = (sg && s != 0) ? 7'h3F : 7'h7F;
    eh = (LZB && h == 0) ? 7'h7F : code_tab[h];
    et = (LZB && h == 0 && t == 0) ? 7'h7F : code_tab[t];
    eo = code_tab[o];
  endtask

  // Watch the scan for one full rotation and record each digit's segments.
  task automatic capture(output logic [6:0] s, h, t, o);
    bit seen [4];
    s = '0; h = '0; t = '0; o = '0;
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    for (int c = 0; c < 40 && !(seen[0] && seen[1] && seen[2] && seen[3]); c++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: begin o = bus.seg; seen[0] = 1'b1; end
        4'b1101: begin t = bus.seg; seen[1] = 1'b1; end
        4'b1011: begin h = bus.seg; seen[2] = 1'b1; end
        4'b0111: begin s = bus.seg; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    chk("scan_all_digits_seen", int'(seen[0] && seen[1] && seen[2] && seen[3]), 1);
  endtask

  // One load, optional ignored second load extra_at cycles after E0.
  task automatic run_case(input string tag, input logic [7:0] s, input logic sg,
                          input int extra_at,
                          input logic [6:0] es, eh, et, eo);
    int busy_n, done_n, done_at;
    logic [6:0] as, ah, at, ao;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk);
    bus.sum  = s;
    bus.sign = sg;
    bus.load = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; done_at = i; end
      if (i == extra_at) begin
        bus.load = 1'b1;
        bus.sum  = 8'd99;
        bus.sign = 1'b0;
      end else begin
        bus.load = 1'b0;
      end
    end
    chk({tag, "_busy_cycles"}, busy_n, 9);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_done_cycle"}, done_at, 10);
    capture(as, ah, at, ao);
    chk({tag, "_sign_seg"}, int'(as), int'(es));
    chk({tag, "_hund_seg"}, int'(ah), int'(eh));
    chk({tag, "_tens_seg"}, int'(at), int'(et));
    chk({tag, "_ones_seg"}, int'(ao), int'(eo));
    chk({tag, "_dp"}, int'(bus.dp), 1);
  endtask

  initial begin
    logic [6:0] es, eh, et, eo, as, ah, at, ao;
    int dcnt;

    vecs[0] = '{8'd62,  1'b0, 0, 7'h7F, Z0,    7'h02, 7'h24};
    vecs[1] = '{8'd255, 1'b1, 0, 7'h3F, 7'h24, 7'h12, 7'h12};
    vecs[2] = '{8'd17,  1'b0, 3, 7'h7F, Z0,    7'h79, 7'h78};
    vecs[3] = '{8'd0,   1'b1, 0, 7'h7F, Z0,    Z0,    7'h40};
    vecs[4] = '{8'd100, 1'b1, 0, 7'h3F, 7'h79, 7'h40, 7'h40};
    vecs[5] = '{8'd5,   1'b0, 0, 7'h7F, Z0,    Z0,    7'h12};
    vecs[6] = '{8'd208, 1'b1, 0, 7'h3F, 7'h24, 7'h40, 7'h00};

    rst = 1'b1;
    bus.load = 1'b0;
    bus.sum  = '0;
    bus.sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_an", int'(bus.an), 'hF);
    chk("rst_seg", int'(bus.seg), 'h7F);
    chk("rst_dp", int'(bus.dp), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;

    // Digit k (0..3) is enabled for 4 clocks each, starting with ones.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("scan_an", int'(bus.an), int'(~(4'b0001 << ((k - 1) / 4)) & 4'hF));
    end

    for (int v = 0; v < 7; v++)
      run_case("vec", vecs[v].sum, vecs[v].sign, vecs[v].extra_at,
               vecs[v].e_s, vecs[v].e_h, vecs[v].e_t, vecs[v].e_o);

    // Reset on the 4th conversion step aborts the load and clears the display.
    @(negedge clk);
    bus.sum = 8'd200; bus.sign = 1'b1; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    capture(as, ah, at, ao);
    chk("abort_sign_seg", int'(as), 'h7F);
    chk("abort_hund_seg", int'(ah), int'(Z0));
    chk("abort_tens_seg", int'(at), int'(Z0));
    chk("abort_ones_seg", int'(ao), 'h40);

    for (int r = 0; r < 20; r++) begin
      logic [7:0] s;
      logic sg;
      s  = 8'($urandom_range(0, 255));
      sg = 1'($urandom_range(0, 1));
      model(int'(s), sg, es, eh, et, eo);
      run_case("rand", s, sg, (r % 3 == 0) ? int'($urandom_range(2, 8)) : 0,
               es, eh, et, eo);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
